// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial feeder for the serial sequence detectors.
// Words enter over valid/ready into a one-word hold register and leave one
// bit per enabled clock on out_bit. Back-to-back words reload straight from
// the hold register, so there is no idle bit between them.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [15:0]      word_count
);

  // state    | meaning
  // ST_IDLE  | nothing shifting; line held at 0, waiting for the hold register
  // ST_SHIFT | shift_reg is being emitted, one bit per out_en cycle

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           r_state,      w_state;
  logic             r_hold_full,  w_hold_full;
  logic [WIDTH-1:0] r_hold_reg,   w_hold_reg;
  logic [WIDTH-1:0] r_shift_reg,  w_shift_reg;
  logic [CW-1:0]    r_bit_cnt,    w_bit_cnt;
  logic [15:0]      r_word_count, w_word_count;

  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;

  // in_ready comes only from registers and reset, never from in_valid.
  assign in_ready = !r_hold_full && !reset;
  assign w_accept = in_valid && in_ready;

  // Shift toward the output end with zero fill.
  assign w_shifted = MSB_FIRST ? {r_shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shift_reg[WIDTH-1:1]};

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hold_full  <= 1'b0;
      r_hold_reg   <= '0;
      r_shift_reg  <= '0;
      r_bit_cnt    <= '0;
      r_word_count <= '0;
    end else begin
      r_state      <= w_state;
      r_hold_full  <= w_hold_full;
      r_hold_reg   <= w_hold_reg;
      r_shift_reg  <= w_shift_reg;
      r_bit_cnt    <= w_bit_cnt;
      r_word_count <= w_word_count;
    end
  end

  // Next-state: load/reload from the hold register, shift, count words.
  // Acceptance needs hold_full=0 and every load needs hold_full=1, so the
  // two updates of the hold register never collide.
  always_comb begin
    w_state      = r_state;
    w_hold_full  = r_hold_full;
    w_hold_reg   = r_hold_reg;
    w_shift_reg  = r_shift_reg;
    w_bit_cnt    = r_bit_cnt;
    w_word_count = r_word_count;

    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_shift_reg = r_hold_reg;
          w_hold_full = 1'b0;
          w_bit_cnt   = '0;
          w_state     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (out_en) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_word_count = r_word_count + 16'd1;
            if (r_hold_full) begin
              w_shift_reg = r_hold_reg;
              w_hold_full = 1'b0;
              w_bit_cnt   = '0;
            end else begin
              w_state = ST_IDLE;
            end
          end else begin
            w_shift_reg = w_shifted;
            w_bit_cnt   = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase

    if (w_accept) begin
      w_hold_reg  = in_data;
      w_hold_full = 1'b1;
    end
  end

  // Outputs are forced low while reset is held; idle line value is 0.
  assign out_valid   = (r_state == ST_SHIFT) && !reset;
  assign out_bit     = out_valid && (MSB_FIRST ? r_shift_reg[WIDTH-1] : r_shift_reg[0]);
  assign frame_start = out_valid && (r_bit_cnt == '0);
  assign frame_end   = out_valid && (r_bit_cnt == LAST_BIT);
  assign busy        = !reset && ((r_state == ST_SHIFT) || r_hold_full);
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: scoreboard of expected bits filled at
// acceptance and drained by a monitor on the falling edge.
module tb_bit_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, out_en;
  logic [W-1:0] in_data;
  logic         in_ready, out_bit, out_valid, frame_start, frame_end, busy;
  logic [15:0]  word_count;

  logic         l_in_valid, l_out_en;
  logic [W-1:0] l_in_data;
  logic         l_in_ready, l_out_bit, l_out_valid, l_frame_start, l_frame_end, l_busy;
  logic [15:0]  l_word_count;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_en(out_en), .out_bit(out_bit),
    .out_valid(out_valid), .frame_start(frame_start), .frame_end(frame_end),
    .busy(busy), .word_count(word_count));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(l_in_data), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .out_en(l_out_en), .out_bit(l_out_bit),
    .out_valid(l_out_valid), .frame_start(l_frame_start), .frame_end(l_frame_end),
    .busy(l_busy), .word_count(l_word_count));

  typedef struct packed {logic b; logic first; logic last;} exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int exp_wc = 0;
  int pops   = 0;
  int vcnt   = 0;
  int cyc    = 0;
  int first_v = -1;
  int last_v  = -1;
  bit mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the serial stream against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      logic [15:0] wc16;
      wc16 = exp_wc[15:0];
      check_eq("word_count", word_count, wc16);
      if (out_valid) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_valid", out_valid, 0);
        end else begin
          check_eq("out_bit", out_bit, sb_q[0].b);
          check_eq("frame_start", frame_start, sb_q[0].first);
          check_eq("frame_end", frame_end, sb_q[0].last);
          if (out_en) begin
            if (sb_q[0].last) exp_wc++;
            void'(sb_q.pop_front());
            pops++;
          end
        end
      end else begin
        check_eq("idle_bit", out_bit, 0);
        check_eq("idle_fs", frame_start, 0);
        check_eq("idle_fe", frame_end, 0);
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int n;
    exp_t e;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("send_ready", in_ready, 1);
    for (int i = 0; i < W; i++) begin
      e.b     = w[W-1-i];
      e.first = (i == 0);
      e.last  = (i == W-1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_busy", busy, 0);
    check_eq("drain_queue", sb_q.size(), 0);
  endtask

  initial begin
    int v0, p0, n, idx;
    logic [W-1:0] lseq;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_en = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_out_en = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_bit", out_bit, 0);
    check_eq("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", in_ready, 1);
    check_eq("post_rst_wc", word_count, 0);
    @(posedge clk); #1;

    // Single word 0xB0
    v0 = vcnt;
    send(8'hB0);
    wait_idle();
    check_eq("b0_valid_cycles", vcnt - v0, 8);
    check_eq("b0_wc", word_count, 1);

    // Back-to-back 0xBB, 0x0B with no gap
    v0 = vcnt; first_v = -1;
    send(8'hBB);
    send(8'h0B);
    check_eq("b2b_ready_low", in_ready, 0);
    wait_idle();
    check_eq("b2b_valid_cycles", vcnt - v0, 16);
    check_eq("b2b_contiguous", last_v - first_v + 1, 16);
    check_eq("b2b_wc", word_count, 3);

    // 0xFF with out_en pattern 1,0,0,1
    p0 = pops; v0 = vcnt;
    fork
      send(8'hFF);
      begin
        for (int i = 0; i < 40; i++) begin
          out_en = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk); #1;
        end
        out_en = 1'b1;
      end
    join
    wait_idle();
    check_eq("stall_advances", pops - p0, 8);
    check_eq("stall_stretched", (vcnt - v0) > 8, 1);
    check_eq("stall_wc", word_count, 4);

    // Reset after 3 bits of 0xA5 while 0x3C is held
    p0 = pops;
    send(8'hA5);
    send(8'h3C);
    n = 0;
    while (pops < p0 + 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rst_mid_reached", pops - p0, 3);
    check_eq("rst_mid_held", busy, 1);
    reset = 1'b1;
    sb_q.delete();
    exp_wc = 0;
    @(negedge clk);
    check_eq("rstm_valid", out_valid, 0);
    check_eq("rstm_bit", out_bit, 0);
    check_eq("rstm_ready", in_ready, 0);
    check_eq("rstm_fs", frame_start, 0);
    check_eq("rstm_fe", frame_end, 0);
    check_eq("rstm_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("after_rst_valid", out_valid, 0);
    check_eq("after_rst_busy", busy, 0);
    check_eq("after_rst_ready", in_ready, 1);
    check_eq("after_rst_wc", word_count, 0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("after_rst_quiet", vcnt >= 0 && !busy, 1);

    // Three words with idle gaps
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] w;
      w = 8'h5A ^ W'(k * 8'h33);
      send(w);
      wait_idle();
      check_eq("gap_wc", word_count, k + 1);
      repeat (5) @(posedge clk);
      #1;
    end

    // LSB-first instance, 0x0D -> 1,0,1,1,0,0,0,0
    lseq = 8'b0000_1101;
    l_in_data = 8'h0D;
    l_in_valid = 1'b1;
    check_eq("lsb_ready", l_in_ready, 1);
    @(posedge clk); #1;
    l_in_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (l_out_valid && idx < W) begin
        check_eq("lsb_bit", l_out_bit, lseq[idx]);
        check_eq("lsb_fs", l_frame_start, idx == 0);
        check_eq("lsb_fe", l_frame_end, idx == W-1);
        idx++;
      end
    end
    check_eq("lsb_count", idx, 8);
    check_eq("lsb_wc", l_word_count, 1);
    check_eq("lsb_valid_end", l_out_valid, 0);

    check_eq("final_queue", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
